// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute bus for the ID/EX pipeline register.
// The master is the decode side; the slave is id_ex_pipe.
interface id_ex_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid_i;
  logic            branch_i, mem_rd_i, mem_to_reg_i, mem_wr_i, a_sel_i, b_sel_i;
  logic            reg_wr_i, jump_i, pc_to_reg_i;
  logic [1:0]      alu_op_i;
  logic            pc_wr_en_i;
  logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]      rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0]      funct3_i;
  logic            funct7b5_i;
  logic            flush_i;

  logic            valid_o;
  logic            branch_o, mem_rd_o, mem_to_reg_o, mem_wr_o, a_sel_o, b_sel_o;
  logic            reg_wr_o, jump_o, pc_to_reg_o;
  logic [1:0]      alu_op_o;
  logic            pc_wr_en_o;
  logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]      rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [2:0]      funct3_o;
  logic            funct7b5_o;
  logic            stall_o;
  logic            halted_o;

  modport master (
    output id_valid_i, branch_i, mem_rd_i, mem_to_reg_i, mem_wr_i, a_sel_i, b_sel_i,
           reg_wr_i, jump_i, pc_to_reg_i, alu_op_i, pc_wr_en_i, pc_i, rs1_data_i,
           rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7b5_i,
           flush_i,
    input  valid_o, branch_o, mem_rd_o, mem_to_reg_o, mem_wr_o, a_sel_o, b_sel_o,
           reg_wr_o, jump_o, pc_to_reg_o, alu_op_o, pc_wr_en_o, pc_o, rs1_data_o,
           rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o, funct7b5_o,
           stall_o, halted_o
  );

  modport slave (
    input  id_valid_i, branch_i, mem_rd_i, mem_to_reg_i, mem_wr_i, a_sel_i, b_sel_i,
           reg_wr_i, jump_i, pc_to_reg_i, alu_op_i, pc_wr_en_i, pc_i, rs1_data_i,
           rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7b5_i,
           flush_i,
    output valid_o, branch_o, mem_rd_o, mem_to_reg_o, mem_wr_o, a_sel_o, b_sel_o,
           reg_wr_o, jump_o, pc_to_reg_o, alu_op_o, pc_wr_en_o, pc_o, rs1_data_o,
           rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o, funct7b5_o,
           stall_o, halted_o
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush and SYSTEM-instruction halt.
// Define ID_EX_LOAD_USE_EN to enable hardware load-use hazard detection.
module id_ex_pipe #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk_i,
  input logic         rst_n_i,
  id_ex_pipe_if.slave bus
);
  typedef struct packed {
    logic       branch, mem_rd, mem_to_reg, mem_wr, a_sel, b_sel, reg_wr, jump, pc_to_reg;
    logic [1:0] alu_op;
    logic       pc_wr_en;
  } ctrl_t;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q;
  logic            valid_q;
  ctrl_t           ctrl_q, ctrl_in;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q;
  logic            lu, bubble, sys_instr;

  assign ctrl_in = {bus.branch_i, bus.mem_rd_i, bus.mem_to_reg_i, bus.mem_wr_i, bus.a_sel_i,
                    bus.b_sel_i, bus.reg_wr_i, bus.jump_i, bus.pc_to_reg_i, bus.alu_op_i,
                    bus.pc_wr_en_i};

`ifdef ID_EX_LOAD_USE_EN
  logic use_rs1, use_rs2;
  assign use_rs1 = !bus.a_sel_i && (bus.alu_op_i != 2'b11);
  assign use_rs2 = !bus.b_sel_i || bus.mem_wr_i || bus.branch_i;
  assign lu = valid_q && ctrl_q.mem_rd && (rd_addr_q != 5'd0) && bus.id_valid_i &&
              ((use_rs1 && (bus.rs1_addr_i == rd_addr_q)) ||
               (use_rs2 && (bus.rs2_addr_i == rd_addr_q)));
`else
  assign lu = 1'b0;
`endif

  assign bubble    = bus.flush_i || (state_q == StHalt) || lu;
  assign sys_instr = bus.id_valid_i && !bus.pc_wr_en_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StRun;
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (sys_instr) begin
      // The SYSTEM instruction never executes; it only parks the core.
      state_q <= StHalt;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q    <= bus.id_valid_i;
      ctrl_q     <= bus.id_valid_i ? ctrl_in : '0;
      pc_q       <= bus.pc_i;
      rs1_data_q <= bus.rs1_data_i;
      rs2_data_q <= bus.rs2_data_i;
      imm_q      <= bus.imm_i;
      rs1_addr_q <= bus.rs1_addr_i;
      rs2_addr_q <= bus.rs2_addr_i;
      rd_addr_q  <= bus.rd_addr_i;
      funct3_q   <= bus.funct3_i;
      funct7b5_q <= bus.funct7b5_i;
    end
  end

  assign bus.valid_o = valid_q;
  assign {bus.branch_o, bus.mem_rd_o, bus.mem_to_reg_o, bus.mem_wr_o, bus.a_sel_o,
          bus.b_sel_o, bus.reg_wr_o, bus.jump_o, bus.pc_to_reg_o, bus.alu_op_o,
          bus.pc_wr_en_o} = ctrl_q;
  assign bus.pc_o       = pc_q;
  assign bus.rs1_data_o = rs1_data_q;
  assign bus.rs2_data_o = rs2_data_q;
  assign bus.imm_o      = imm_q;
  assign bus.rs1_addr_o = rs1_addr_q;
  assign bus.rs2_addr_o = rs2_addr_q;
  assign bus.rd_addr_o  = rd_addr_q;
  assign bus.funct3_o   = funct3_q;
  assign bus.funct7b5_o = funct7b5_q;
  // Flush kills a wrong-path dependent, so it must not hold the front end.
  assign bus.stall_o    = (state_q == StHalt) || (lu && !bus.flush_i);
  assign bus.halted_o   = (state_q == StHalt);
endmodule
